// File: rtl/score_display_sequencer.sv
// rtl/score_display_sequencer.sv - credit/win display sequencer with BCD conversion and 5-digit scan
module score_display_sequencer #(
    parameter int SCAN_DIV = 25000,
    parameter int WIN_HOLD = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_spin,
    input  logic        spin_done,
    input  logic [11:0] win_credits,
    input  logic        is_win,
    input  logic [11:0] total_credits,
    input  logic        is_total,
    output logic [4:0]  select,
    output logic [6:0]  seven_segment_output,
    output logic        busy
);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW  = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_T     = 7'b0000111;

    typedef enum logic [1:0] {S_TOTAL, S_SPIN, S_CONV, S_WIN} state_t;

    state_t           state_q, state_d;
    logic             start_q, done_q;
    logic [11:0]      tot_reg_q, win_reg_q, tot_last_q;
    logic             win_pend_q;
    logic             conv_busy_q, conv_done_q, conv_src_q;
    logic [3:0]       conv_cnt_q;
    logic [11:0]      conv_bin_q;
    logic [15:0]      conv_bcd_q, bcd_adj;
    logic [15:0]      disp_bcd_q;
    logic             disp_win_q;
    logic [HW-1:0]    hold_cnt_q;
    logic [SCW-1:0]   scan_cnt_q;
    logic [2:0]       digit_q;
    logic [4:0]       select_q, select_d;
    logic [6:0]       seg_q, seg_d;
    logic             start_edge, done_edge, conv_start, conv_win;

    assign start_edge           = start_spin & ~start_q;
    assign done_edge            = spin_done & ~done_q;
    assign select               = select_q;
    assign seven_segment_output = seg_q;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_TOTAL;
        else       state_q <= state_d;
    end

    // Next state; a start_spin edge overrides everything, including a same-cycle spin_done edge
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        conv_win   = 1'b0;
        if (start_edge) begin
            state_d = S_SPIN;
        end else begin
            case (state_q)
                S_SPIN: if (done_edge) begin
                    state_d    = S_CONV;
                    conv_start = 1'b1;
                    conv_win   = win_pend_q && (win_reg_q != 12'd0);
                end
                S_CONV: if (conv_done_q) state_d = conv_src_q ? S_WIN : S_TOTAL;
                S_WIN: if (hold_cnt_q == HW'(WIN_HOLD - 1)) begin
                    state_d    = S_TOTAL;
                    conv_start = 1'b1;
                end
                default: if (!conv_busy_q && !conv_done_q && (tot_reg_q != tot_last_q))
                    conv_start = 1'b1;
            endcase
        end
    end

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        bcd_adj = conv_bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (conv_bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = conv_bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // Input capture, edge history, sequential BCD converter, display latch and hold counter
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            tot_reg_q   <= '0;
            win_reg_q   <= '0;
            tot_last_q  <= '0;
            win_pend_q  <= 1'b0;
            conv_busy_q <= 1'b0;
            conv_done_q <= 1'b0;
            conv_src_q  <= 1'b0;
            conv_cnt_q  <= '0;
            conv_bin_q  <= '0;
            conv_bcd_q  <= '0;
            disp_bcd_q  <= '0;
            disp_win_q  <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            start_q <= start_spin;
            done_q  <= spin_done;
            if (is_total) tot_reg_q <= total_credits;
            if (is_win)   win_reg_q <= win_credits;

            if (start_edge)                                  win_pend_q <= 1'b0;
            else if (is_win)                                 win_pend_q <= 1'b1;
            else if (state_q == S_CONV && conv_done_q && conv_src_q) win_pend_q <= 1'b0;

            if (start_edge) begin
                conv_busy_q <= 1'b0;
                conv_done_q <= 1'b0;
            end else if (conv_start) begin
                conv_busy_q <= 1'b1;
                conv_done_q <= 1'b0;
                conv_cnt_q  <= '0;
                conv_src_q  <= conv_win;
                conv_bin_q  <= conv_win ? win_reg_q : tot_reg_q;
                conv_bcd_q  <= '0;
                if (!conv_win) tot_last_q <= tot_reg_q;
            end else if (conv_busy_q) begin
                {conv_bcd_q, conv_bin_q} <= {bcd_adj, conv_bin_q} << 1;
                conv_cnt_q <= conv_cnt_q + 4'd1;
                if (conv_cnt_q == 4'd11) begin
                    conv_busy_q <= 1'b0;
                    conv_done_q <= 1'b1;
                end
            end else begin
                conv_done_q <= 1'b0;
            end

            // Value and prefix change together so a half-updated display never appears
            if (conv_done_q && !start_edge) begin
                disp_bcd_q <= conv_bcd_q;
                disp_win_q <= conv_src_q;
            end

            if (state_q == S_WIN) hold_cnt_q <= hold_cnt_q + HW'(1);
            else                  hold_cnt_q <= '0;
        end
    end

    // Digit scan timing
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
        end else if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            digit_q    <= (digit_q == 3'd4) ? 3'd0 : digit_q + 3'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + SCW'(1);
        end
    end

    // Output decode: segment pattern for the current digit, busy flag
    always_comb begin
        logic [3:0] dig;
        logic       blank;
        dig      = 4'd0;
        blank    = 1'b0;
        busy     = (state_q != S_TOTAL);
        select_d = ~(5'b00001 << digit_q);
        case (digit_q)
            3'd0:    dig = disp_bcd_q[3:0];
            3'd1: begin dig = disp_bcd_q[7:4];   blank = (disp_bcd_q[15:4] == 12'd0); end
            3'd2: begin dig = disp_bcd_q[11:8];  blank = (disp_bcd_q[15:8] == 8'd0);  end
            3'd3: begin dig = disp_bcd_q[15:12]; blank = (disp_bcd_q[15:12] == 4'd0); end
            default: dig = 4'd0;
        endcase
        if (state_q == S_SPIN || state_q == S_CONV) seg_d = SEG_DASH;
        else if (digit_q == 3'd4)                   seg_d = disp_win_q ? SEG_P : SEG_T;
        else if (blank)                             seg_d = SEG_BLANK;
        else                                        seg_d = seg7(dig);
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            select_q <= 5'b11111;
            seg_q    <= SEG_BLANK;
        end else begin
            select_q <= select_d;
            seg_q    <= seg_d;
        end
    end
endmodule

// File: tb/tb_score_display_sequencer.sv
// tb/tb_score_display_sequencer.sv - scoreboard bench for score_display_sequencer
module tb_score_display_sequencer;
    localparam int SD = 4;
    localparam int WH = 200;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111, DA = 7'b0111111, SP = 7'b0001100, ST = 7'b0000111;

    logic        clk = 1'b0;
    logic        reset, start_spin, spin_done, is_win, is_total;
    logic [11:0] win_credits, total_credits;
    logic [4:0]  select;
    logic [6:0]  seven_segment_output;
    logic        busy;

    typedef struct {
        logic [34:0] segs;
        logic        busy;
        longint      t;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    score_display_sequencer #(.SCAN_DIV(SD), .WIN_HOLD(WH)) dut (
        .clk(clk), .reset(reset), .start_spin(start_spin), .spin_done(spin_done),
        .win_credits(win_credits), .is_win(is_win),
        .total_credits(total_credits), .is_total(is_total),
        .select(select), .seven_segment_output(seven_segment_output), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [34:0] mk(input logic [6:0] d4, d3, d2, d1, d0);
        return {d4, d3, d2, d1, d0};
    endfunction

    // Monitor: digit dwell time and frame comparison against the scoreboard
    logic [4:0]  prev_sel = 5'b11111;
    int          run = 0;
    logic [34:0] fsegs = '0;
    logic [4:0]  seen = '0;
    longint      fstart = 0;
    always @(negedge clk) begin
        int k;
        k = -1;
        case (select)
            5'b11110: k = 0;
            5'b11101: k = 1;
            5'b11011: k = 2;
            5'b10111: k = 3;
            5'b01111: k = 4;
            default:  k = -1;
        endcase
        if (select != prev_sel) begin
            if (prev_sel != 5'b11111 && select != 5'b11111) begin
                total++;
                if (run != SD) begin
                    bad++;
                    $display("FAIL dwell sel=%b got=%0d want=%0d", prev_sel, run, SD);
                end
            end
            run = 1;
            prev_sel = select;
        end else begin
            run++;
        end
        if (k < 0) begin
            seen = '0;
        end else begin
            if (k == 0) begin
                seen = '0;
                fstart = cyc;
            end
            fsegs[k*7 +: 7] = seven_segment_output;
            seen[k] = 1'b1;
            if (k == 4 && seen == 5'b11111) begin
                if (sb.size() > 0 && sb[0].t < fstart) begin
                    exp_t e;
                    e = sb.pop_front();
                    total++;
                    if (fsegs !== e.segs || busy !== e.busy) begin
                        bad++;
                        $display("FAIL frame got=%h busy=%b want=%h busy=%b", fsegs, busy, e.segs, e.busy);
                    end
                end
                seen = '0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_frame(input logic [34:0] s, input logic b);
        exp_t e;
        e.segs = s;
        e.busy = b;
        e.t    = cyc;
        sb.push_back(e);
        step(45);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic pulse_start;
        start_spin = 1'b1;
        step(2);
        start_spin = 1'b0;
    endtask

    task automatic pulse_done;
        spin_done = 1'b1;
        step(2);
        spin_done = 1'b0;
    endtask

    task automatic load_win(input logic [11:0] v);
        win_credits = v;
        is_win = 1'b1;
        step(1);
        is_win = 1'b0;
    endtask

    task automatic load_total(input logic [11:0] v);
        total_credits = v;
        is_total = 1'b1;
        step(1);
        is_total = 1'b0;
    endtask

    initial begin
        logic busy_seen;
        reset = 1'b1; start_spin = 1'b0; spin_done = 1'b0;
        is_win = 1'b0; is_total = 1'b0; win_credits = '0; total_credits = '0;
        step(3);
        chk("rst_select", 32'(select), 32'h1f);
        chk("rst_seg", 32'(seven_segment_output), 32'h7f);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        step(1);
        chk("first_select", 32'(select), 32'h1e);
        chk("first_seg", 32'(seven_segment_output), 32'(S0));
        expect_frame(mk(ST, BL, BL, BL, S0), 1'b0);

        load_total(12'd1234);
        busy_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            busy_seen |= busy;
            step(1);
        end
        chk("busy_total_conv", 32'(busy_seen), 32'h0);
        expect_frame(mk(ST, S1, S2, S3, S4), 1'b0);

        // start_spin held high across the whole spin: only one edge may be seen
        start_spin = 1'b1;
        step(3);
        expect_frame(mk(DA, DA, DA, DA, DA), 1'b1);
        load_win(12'd50);
        pulse_done();
        step(16);
        expect_frame(mk(SP, BL, BL, S5, S0), 1'b1);
        start_spin = 1'b0;
        step(200);
        expect_frame(mk(ST, S1, S2, S3, S4), 1'b0);

        // zero win goes straight to total
        pulse_start();
        load_win(12'd0);
        pulse_done();
        step(16);
        expect_frame(mk(ST, S1, S2, S3, S4), 1'b0);

        // no win, total changed during spin
        pulse_start();
        load_total(12'd7);
        pulse_done();
        step(16);
        expect_frame(mk(ST, BL, BL, BL, S7), 1'b0);

        // abort from SHOW_WIN
        pulse_start();
        load_win(12'd99);
        pulse_done();
        step(20);
        expect_frame(mk(SP, BL, BL, S9, S9), 1'b1);
        pulse_start();
        step(2);
        expect_frame(mk(DA, DA, DA, DA, DA), 1'b1);
        pulse_done();
        step(16);
        expect_frame(mk(ST, BL, BL, BL, S7), 1'b0);

        // abort mid-conversion; pending win must be dropped
        pulse_start();
        load_win(12'd300);
        pulse_done();
        step(5);
        pulse_start();
        step(2);
        expect_frame(mk(DA, DA, DA, DA, DA), 1'b1);
        pulse_done();
        step(16);
        expect_frame(mk(ST, BL, BL, BL, S7), 1'b0);

        // simultaneous start_spin and spin_done edges
        pulse_start();
        step(3);
        load_win(12'd42);
        start_spin = 1'b1;
        spin_done = 1'b1;
        step(2);
        start_spin = 1'b0;
        spin_done = 1'b0;
        step(16);
        expect_frame(mk(DA, DA, DA, DA, DA), 1'b1);
        pulse_done();
        step(16);
        expect_frame(mk(ST, BL, BL, BL, S7), 1'b0);

        load_total(12'd4095);
        step(16);
        expect_frame(mk(ST, S4, S0, S9, S5), 1'b0);

        // reset during the win hold
        pulse_start();
        load_win(12'd50);
        pulse_done();
        step(30);
        reset = 1'b1;
        step(1);
        chk("midhold_select", 32'(select), 32'h1f);
        chk("midhold_seg", 32'(seven_segment_output), 32'h7f);
        chk("midhold_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        step(2);
        expect_frame(mk(ST, BL, BL, BL, S0), 1'b0);

        step(60);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
